// File: rtl/nn_ctrl_pkg.sv
// Shared definitions for the LSTM sequence controller: FSM state encoding,
// LFSR tap mask, default seed and the LFSR step function.
package nn_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_LATCH = 3'd3,
        ST_DONE  = 3'd4
    } ctrl_state_e;

    // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
    localparam int          RC_W              = 5;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/nn_lfsr16.sv
// 16-bit Fibonacci LFSR with enable and synchronous reset to SEED; exposes
// only the low bits consumed as ADDSUB random-condition bits.
module nn_lfsr16
    import nn_ctrl_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    output logic [RC_W-1:0] q_lo
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q_lo = lfsr_q[RC_W-1:0];

endmodule

// File: rtl/nn_lstm_seq_ctrl.sv
// Sequencer for a stochastic LSTM node: clears the node, runs WARMUP+L
// bitstream cycles per timestep, counts output ones and reports each step.
module nn_lstm_seq_ctrl
    import nn_ctrl_pkg::*;
#(
    parameter int          LEN_W     = 10,
    parameter int          STEP_W    = 4,
    parameter int          WARMUP    = 2,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input  logic              CLK,
    input  logic              INIT,
    input  logic              start,
    input  logic              abort,
    input  logic [STEP_W-1:0] n_steps,
    input  logic [LEN_W-1:0]  stream_len,
    input  logic [3:0]        z_offset_cfg,
    input  logic              a_out,
    output logic              node_init,
    output logic [RC_W-1:0]   rc,
    output logic [3:0]        z_offset,
    output logic              a_last_load,
    output logic              step_valid,
    output logic [LEN_W-1:0]  step_count,
    output logic [STEP_W-1:0] step_idx,
    output logic              busy,
    output logic              done
);

    localparam int RUN_W = $clog2(WARMUP + (1 << LEN_W));

    ctrl_state_e       state_q, state_d;
    logic              clr_cnt_q, clr_cnt_d;
    logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
    logic [LEN_W-1:0]  ones_q, ones_d;
    logic [STEP_W-1:0] idx_q, idx_d;
    logic [STEP_W-1:0] nsteps_q, nsteps_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [3:0]        z_offset_q, z_offset_d;
    logic [LEN_W-1:0]  step_count_q, step_count_d;
    logic [STEP_W-1:0] step_idx_q, step_idx_d;

    logic [LEN_W-1:0]  len_eff;
    logic [RUN_W-1:0]  run_last;
    logic              counting;
    logic              last_step;
    logic [RC_W-1:0]   lfsr_lo;

    nn_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk  (CLK),
        .rst  (INIT),
        .en   (state_q == ST_RUN),
        .q_lo (lfsr_lo)
    );

    assign len_eff   = (len_q == '0) ? LEN_W'(1) : len_q;
    assign run_last  = RUN_W'(WARMUP) + RUN_W'(len_eff) - RUN_W'(1);
    assign counting  = (run_cnt_q >= RUN_W'(WARMUP));
    assign last_step = (idx_q == nsteps_q - STEP_W'(1));

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        run_cnt_d    = run_cnt_q;
        ones_d       = ones_q;
        idx_d        = idx_q;
        nsteps_d     = nsteps_q;
        len_d        = len_q;
        z_offset_d   = z_offset_q;
        step_count_d = step_count_q;
        step_idx_d   = step_idx_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (n_steps != '0) begin
                        nsteps_d   = n_steps;
                        len_d      = stream_len;
                        z_offset_d = z_offset_cfg;
                        idx_d      = '0;
                        clr_cnt_d  = 1'b0;
                        state_d    = ST_CLEAR;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_CLEAR: begin
                run_cnt_d = '0;
                ones_d    = '0;
                if (clr_cnt_q) begin
                    state_d = ST_RUN;
                end else begin
                    clr_cnt_d = 1'b1;
                end
            end
            ST_RUN: begin
                run_cnt_d = run_cnt_q + RUN_W'(1);
                if (counting) begin
                    ones_d = ones_q + LEN_W'(a_out);
                end
                if (run_cnt_q == run_last) begin
                    step_count_d = ones_d;
                    step_idx_d   = idx_q;
                    state_d      = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (last_step) begin
                    state_d = ST_DONE;
                end else begin
                    // next timestep reuses node state, so CLEAR is skipped
                    idx_d     = idx_q + STEP_W'(1);
                    ones_d    = '0;
                    run_cnt_d = '0;
                    state_d   = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // abort wins over every transition and leaves the reported step untouched
        if (abort && (state_q != ST_IDLE)) begin
            state_d      = ST_IDLE;
            step_count_d = step_count_q;
            step_idx_d   = step_idx_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (INIT) begin
            state_q      <= ST_IDLE;
            clr_cnt_q    <= 1'b0;
            run_cnt_q    <= '0;
            ones_q       <= '0;
            idx_q        <= '0;
            nsteps_q     <= '0;
            len_q        <= '0;
            z_offset_q   <= '0;
            step_count_q <= '0;
            step_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            run_cnt_q    <= run_cnt_d;
            ones_q       <= ones_d;
            idx_q        <= idx_d;
            nsteps_q     <= nsteps_d;
            len_q        <= len_d;
            z_offset_q   <= z_offset_d;
            step_count_q <= step_count_d;
            step_idx_q   <= step_idx_d;
        end
    end

    assign node_init   = !INIT && (state_q == ST_CLEAR);
    assign rc          = (!INIT && (state_q == ST_RUN)) ? lfsr_lo : '0;
    assign step_valid  = !INIT && !abort && (state_q == ST_LATCH);
    assign a_last_load = !INIT && !abort && (state_q == ST_LATCH);
    assign done        = !INIT && !abort && (state_q == ST_DONE);
    assign busy        = !INIT && (state_q != ST_IDLE);
    assign z_offset    = INIT ? '0 : z_offset_q;
    assign step_count  = INIT ? '0 : step_count_q;
    assign step_idx    = INIT ? '0 : step_idx_q;

endmodule

// File: tb/tb_nn_lstm_seq_ctrl.sv
// Bench for nn_lstm_seq_ctrl: each sequence is expanded into a per-cycle
// phase timeline (CLEAR / warm-up / counted / LATCH / DONE) and compared live.
module tb_nn_lstm_seq_ctrl;

    localparam int          LEN_W  = 10;
    localparam int          STEP_W = 4;
    localparam int          WARMUP = 2;
    localparam logic [15:0] SEED   = 16'hACE1;
    localparam int          MAXC   = 1024;

    logic              clk;
    logic              INIT;
    logic              start;
    logic              abort;
    logic [STEP_W-1:0] n_steps;
    logic [LEN_W-1:0]  stream_len;
    logic [3:0]        z_offset_cfg;
    logic              a_out;
    logic              node_init;
    logic [4:0]        rc;
    logic [3:0]        z_offset;
    logic              a_last_load;
    logic              step_valid;
    logic [LEN_W-1:0]  step_count;
    logic [STEP_W-1:0] step_idx;
    logic              busy;
    logic              done;

    nn_lstm_seq_ctrl #(
        .LEN_W(LEN_W), .STEP_W(STEP_W), .WARMUP(WARMUP), .LFSR_SEED(SEED)
    ) dut (
        .CLK(clk), .INIT(INIT), .start(start), .abort(abort),
        .n_steps(n_steps), .stream_len(stream_len), .z_offset_cfg(z_offset_cfg),
        .a_out(a_out), .node_init(node_init), .rc(rc), .z_offset(z_offset),
        .a_last_load(a_last_load), .step_valid(step_valid), .step_count(step_count),
        .step_idx(step_idx), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {E_IDLE, E_CLEAR, E_WARM, E_CNT, E_LATCH, E_DONE} ent_e;

    int   n_chk;
    int   n_fail;
    ent_e etype [MAXC];
    int   estep [MAXC];
    int   n_ent;

    logic [15:0]       lfsr_m;
    logic [LEN_W-1:0]  held_cnt;
    logic [STEP_W-1:0] held_idx;
    logic [3:0]        held_z;
    int                ones_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
        logic fb;
        fb = x[15] ^ x[13] ^ x[12] ^ x[10];
        return {x[14:0], fb};
    endfunction

    task automatic reset_model();
        lfsr_m   = SEED;
        held_cnt = '0;
        held_idx = '0;
        held_z   = '0;
        ones_m   = 0;
    endtask

    task automatic add_ent(input ent_e t, input int s);
        etype[n_ent] = t;
        estep[n_ent] = s;
        n_ent++;
    endtask

    task automatic build(input int nst, input int len);
        int l;
        l = (len == 0) ? 1 : len;
        n_ent = 0;
        if (nst == 0) begin
            add_ent(E_DONE, 0);
        end else begin
            add_ent(E_CLEAR, 0);
            add_ent(E_CLEAR, 0);
            for (int s = 0; s < nst; s++) begin
                for (int w = 0; w < WARMUP; w++) add_ent(E_WARM, s);
                for (int c = 0; c < l; c++) add_ent(E_CNT, s);
                add_ent(E_LATCH, s);
            end
            add_ent(E_DONE, 0);
        end
        add_ent(E_IDLE, 0);
        add_ent(E_IDLE, 0);
    endtask

    task automatic check_outs(input ent_e t, input int s);
        if (t == E_LATCH) begin
            held_cnt = LEN_W'(ones_m);
            held_idx = STEP_W'(s);
            ones_m   = 0;
        end
        chk("busy", 32'(busy), 32'(t != E_IDLE));
        chk("node_init", 32'(node_init), 32'(t == E_CLEAR));
        chk("step_valid", 32'(step_valid), 32'(t == E_LATCH));
        chk("a_last_load", 32'(a_last_load), 32'(t == E_LATCH));
        chk("done", 32'(done), 32'(t == E_DONE));
        if (t == E_WARM || t == E_CNT) begin
            chk("rc", 32'(rc), 32'(lfsr_m[4:0]));
            lfsr_m = lfsr_adv(lfsr_m);
        end else begin
            chk("rc_zero", 32'(rc), 32'(0));
        end
        chk("step_count", 32'(step_count), 32'(held_cnt));
        chk("step_idx", 32'(step_idx), 32'(held_idx));
        chk("z_offset", 32'(z_offset), 32'(held_z));
    endtask

    // amode: 0 random, 1 constant one, 2 alternating; kill_at -2 picks a random point
    task automatic run_seq(input int nst, input int len, input logic [3:0] zcfg,
                           input int amode, input int kill_at_in, input bit kill_init,
                           input bit busy_starts);
        int kill_at;
        build(nst, len);
        kill_at = kill_at_in;
        if (kill_at == -2) kill_at = $urandom_range(0, n_ent - 3);
        @(negedge clk);
        n_steps      = STEP_W'(nst);
        stream_len   = LEN_W'(len);
        z_offset_cfg = zcfg;
        start        = 1'b1;
        if (nst != 0) held_z = zcfg;
        ones_m = 0;
        for (int j = 0; j < n_ent; j++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            check_outs(etype[j], estep[j]);
            if (j == kill_at) begin
                if (kill_init) begin
                    INIT = 1'b1;
                    #1;
                    chk("init_gate", {27'd0, busy, node_init, step_valid, done, a_last_load}, 32'd0);
                    @(negedge clk);
                    reset_model();
                    check_outs(E_IDLE, 0);
                    INIT = 1'b0;
                    @(negedge clk);
                    check_outs(E_IDLE, 0);
                end else begin
                    abort = 1'b1;
                    #1;
                    chk("abort_gate", {29'd0, done, step_valid, a_last_load}, 32'd0);
                    @(negedge clk);
                    abort = 1'b0;
                    check_outs(E_IDLE, 0);
                    @(negedge clk);
                    check_outs(E_IDLE, 0);
                end
                break;
            end
            case (amode)
                1:       a_out = 1'b1;
                2:       a_out = j[0];
                default: a_out = 1'($urandom_range(0, 1));
            endcase
            if (etype[j] == E_CNT) ones_m += int'(a_out);
            if (busy_starts && etype[j] != E_IDLE && $urandom_range(0, 2) == 0) begin
                start        = 1'b1;
                n_steps      = STEP_W'($urandom_range(0, 15));
                stream_len   = LEN_W'($urandom_range(0, 1023));
                z_offset_cfg = 4'($urandom_range(0, 15));
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int nst;
        int len;
        n_chk        = 0;
        n_fail       = 0;
        INIT         = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        n_steps      = '0;
        stream_len   = '0;
        z_offset_cfg = '0;
        a_out        = 1'b0;
        reset_model();
        repeat (3) @(negedge clk);
        check_outs(E_IDLE, 0);
        INIT = 1'b0;
        @(negedge clk);
        check_outs(E_IDLE, 0);

        run_seq(3, 8, 4'hA, 1, -1, 1'b0, 1'b0);
        chk("three_step_count", 32'(step_count), 32'd8);
        chk("three_step_idx", 32'(step_idx), 32'd2);

        run_seq(1, 0, 4'h5, 1, -1, 1'b0, 1'b0);
        chk("len0_count", 32'(step_count), 32'd1);

        run_seq(0, 5, 4'hF, 0, -1, 1'b0, 1'b0);

        // abort in RUN of step 1 (entries 13..22), then restart
        run_seq(3, 8, 4'h3, 0, 15, 1'b0, 1'b0);
        run_seq(2, 4, 4'hC, 0, -1, 1'b0, 1'b0);

        run_seq(2, 10, 4'h6, 2, -1, 1'b0, 1'b1);
        chk("alt_count", 32'(step_count), 32'd5);

        @(negedge clk);
        start   = 1'b1;
        abort   = 1'b1;
        n_steps = STEP_W'(2);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_outs(E_IDLE, 0);
        @(negedge clk);
        check_outs(E_IDLE, 0);

        run_seq(3, 6, 4'h9, 0, 14, 1'b1, 1'b0);
        run_seq(1, 3, 4'h2, 0, -1, 1'b0, 1'b0);

        for (int it = 0; it < 30; it++) begin
            nst = $urandom_range(0, 4);
            len = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 24);
            run_seq(nst, len, 4'($urandom_range(0, 15)), 0,
                    ($urandom_range(0, 4) == 0) ? -2 : -1,
                    1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
